// File: rtl/max_pool_2x2_stream_pkg.sv
// Shared types and constants for the pooling/conv datapath: FP32 word width,
// common FP32 constants and counter-width helpers.
package max_pool_2x2_stream_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/max_pool_2x2_stream_fp_max.sv
// Combinational maximum of two IEEE-754 words by sign/magnitude compare;
// +0 beats -0, NaN/Inf ordering is not meaningful.
module max_pool_2x2_stream_fp_max
  import max_pool_2x2_stream_pkg::*;
#(
  parameter int DW = max_pool_2x2_stream_pkg::DATA_WIDTH
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = b;
    case ({a[DW-1], b[DW-1]})
      2'b00:   y = (a > b) ? a : b;
      2'b11:   y = (a < b) ? a : b;
      2'b01:   y = a;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/max_pool_2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-order FP32 pixel stream; one pooled
// word per window, emitted the cycle after the window's bottom-right pixel.
module max_pool_2x2_stream
  import max_pool_2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = max_pool_2x2_stream_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam int LD = IMG_WIDTH / 2;
  localparam int LW = cnt_w(LD);

  if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
    $error("max_pool_2x2_stream: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
    $error("max_pool_2x2_stream: IMG_HEIGHT must be even and >= 2");
  end

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] linebuf_q [LD];
  logic [DATA_WIDTH-1:0] linebuf_d [LD];

  logic                  col_last, row_last;
  logic [LW-1:0]         lb_idx;
  logic [DATA_WIDTH-1:0] lb_rd, h_max, v_max;

  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
  assign lb_idx   = LW'(col_q >> 1);
  assign lb_rd    = linebuf_q[lb_idx];

  max_pool_2x2_stream_fp_max #(.DW(DATA_WIDTH)) u_hmax (
    .a (hold_q),
    .b (data_in),
    .y (h_max)
  );

  // The odd-row read sees the pair maximum stored during the even row above.
  max_pool_2x2_stream_fp_max #(.DW(DATA_WIDTH)) u_vmax (
    .a (lb_rd),
    .b (h_max),
    .y (v_max)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    linebuf_d    = linebuf_q;
    if (clr) begin
      col_d      = '0;
      row_d      = '0;
      hold_d     = DATA_WIDTH'(FP_ZERO);
      data_out_d = DATA_WIDTH'(FP_ZERO);
    end else if (valid_in) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + 1'b1;
      end
      if (!col_q[0]) begin
        hold_d = data_in;
      end else if (!row_q[0]) begin
        linebuf_d[lb_idx] = h_max;
      end else begin
        data_out_d   = v_max;
        valid_out_d  = 1'b1;
        frame_done_d = col_last && row_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= DATA_WIDTH'(FP_ZERO);
      data_out_q   <= DATA_WIDTH'(FP_ZERO);
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer holds data only; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    linebuf_q <= linebuf_d;
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule
